// File: rtl/delay_echo_mixer.sv
// Echo mixer: adds the delayed (wet) sample to the live (dry) sample once the
// delay line has filled, fading the echo in with a stepped shift ramp.
//
// state | meaning
// IDLE  | disabled, wet term zero, outputs not valid
// FILL  | delay line filling, dry only
// RAMP  | echo fading in, eff_shift stepping down from 7
// RUN   | steady state, shift taken straight from config
module delay_echo_mixer #(
    parameter int FILL_DEPTH = 30,
    parameter int RAMP_STEP  = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] dry_in,
    input  logic [7:0] wet_in,
    input  logic       cfg_we,
    input  logic [7:0] cfg_data,
    output logic [7:0] mix_out,
    output logic       mix_valid,
    output logic [1:0] state_o
);

    localparam int FW = (FILL_DEPTH > 1) ? $clog2(FILL_DEPTH) : 1;
    localparam int RW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_DEPTH - 1);
    localparam logic [RW-1:0] STEP_LAST = RW'(RAMP_STEP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RAMP = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    logic [RW-1:0] step_cnt_q, step_cnt_d;
    logic [2:0]    eff_shift_q, eff_shift_d;
    logic [4:0]    cfg_q, cfg_d;

    logic [7:0]    s1_dry_q, s1_dry_d;
    logic [7:0]    s1_wet_q, s1_wet_d;
    logic          s1_wet_only_q, s1_wet_only_d;
    logic          s1_mute_q, s1_mute_d;
    logic          s1_active_q, s1_active_d;
    logic [7:0]    mix_out_q, mix_out_d;
    logic          mix_valid_q, mix_valid_d;

    logic [2:0]    wet_shift;
    logic          mute;
    logic          wet_only;
    logic [8:0]    sum;
    logic          cfg_unused;

    assign wet_shift  = cfg_q[2:0];
    assign mute       = cfg_q[3];
    assign wet_only   = cfg_q[4];
    assign cfg_unused = ^cfg_data[7:5];

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_we) begin
            cfg_d = cfg_data[4:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        step_cnt_d  = step_cnt_q;
        eff_shift_d = eff_shift_q;
        if (!enable) begin
            state_d     = S_IDLE;
            fill_cnt_d  = '0;
            step_cnt_d  = '0;
            eff_shift_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_FILL;
                    fill_cnt_d = '0;
                end
                S_FILL: begin
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d     = S_RAMP;
                        eff_shift_d = 3'd7;
                        step_cnt_d  = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FW'(1);
                    end
                end
                S_RAMP: begin
                    // Checked every cycle so a config write can cut the ramp short.
                    if (eff_shift_q <= wet_shift) begin
                        state_d     = S_RUN;
                        eff_shift_d = wet_shift;
                        step_cnt_d  = '0;
                    end else if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d  = '0;
                        eff_shift_d = eff_shift_q - 3'd1;
                        if ((eff_shift_q - 3'd1) <= wet_shift) begin
                            state_d = S_RUN;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + RW'(1);
                    end
                end
                S_RUN: begin
                    eff_shift_d = wet_shift;
                    step_cnt_d  = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s1_dry_d      = dry_in;
        s1_wet_only_d = wet_only;
        s1_mute_d     = mute;
        s1_active_d   = (state_q != S_IDLE);
        case (state_q)
            S_RAMP:  s1_wet_d = wet_in >> eff_shift_q;
            S_RUN:   s1_wet_d = wet_in >> wet_shift;
            default: s1_wet_d = 8'd0;
        endcase
    end

    always_comb begin
        if (s1_wet_only_q) begin
            sum = {1'b0, s1_wet_q};
        end else begin
            sum = {1'b0, s1_dry_q} + {1'b0, s1_wet_q};
        end
        mix_out_d   = sum[8] ? 8'hFF : sum[7:0];
        if (s1_mute_q) begin
            mix_out_d = 8'd0;
        end
        mix_valid_d = s1_active_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            fill_cnt_q    <= '0;
            step_cnt_q    <= '0;
            eff_shift_q   <= '0;
            cfg_q         <= '0;
            s1_dry_q      <= '0;
            s1_wet_q      <= '0;
            s1_wet_only_q <= 1'b0;
            s1_mute_q     <= 1'b0;
            s1_active_q   <= 1'b0;
            mix_out_q     <= '0;
            mix_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_cnt_q    <= fill_cnt_d;
            step_cnt_q    <= step_cnt_d;
            eff_shift_q   <= eff_shift_d;
            cfg_q         <= cfg_d;
            s1_dry_q      <= s1_dry_d;
            s1_wet_q      <= s1_wet_d;
            s1_wet_only_q <= s1_wet_only_d;
            s1_mute_q     <= s1_mute_d;
            s1_active_q   <= s1_active_d;
            mix_out_q     <= mix_out_d;
            mix_valid_q   <= mix_valid_d;
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign state_o   = state_q;

endmodule
